// File: rtl/decode.sv
// decode: instruction decode stage between fetch and execute.
// Splits the instruction word into its fields, reads the register file,
// sign-extends the immediate, and presents a registered operand bundle
// with a valid/ready handshake toward execute. The block has two states,
// RUN and HALT. An hlt instruction parks it in HALT until a resume pulse.
// Illegal opecodes are dropped and raise a sticky flag.
// Optional build macro DECODE_NOP_DROP_EN: when defined, nop instructions
// are consumed here instead of being forwarded to execute.

module decode #(
    parameter int LEN_INSN    = 32,
    parameter int LEN_OPECODE = 7,
    parameter int LEN_IMMF    = 1,
    parameter int LEN_REG     = 32,
    parameter int LEN_REGNO   = 4,
    parameter int LEN_CC      = 4,
    parameter int LEN_IMM_EX  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LEN_INSN-1:0]    insn,

    output logic [LEN_REGNO-1:0]   rf_addr_rd,
    output logic [LEN_REGNO-1:0]   rf_addr_rs,
    input  logic [LEN_REG-1:0]     rf_data_rd,
    input  logic [LEN_REG-1:0]     rf_data_rs,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LEN_OPECODE-1:0] opecode,
    output logic [LEN_IMMF-1:0]    immf,
    output logic [LEN_REG-1:0]     data_rd,
    output logic [LEN_REG-1:0]     data_rs,
    output logic [LEN_CC-1:0]      cc,
    output logic [LEN_IMM_EX-1:0]  imm_ex,
    output logic [LEN_REGNO-1:0]   rd_no,

    output logic                   halted,
    input  logic                   resume,
    output logic                   illegal
);

    // Field layout: opecode | immf | rd | rs | imm16. cc overlaps the top of imm16.
    localparam int LEN_IMM  = 16;
    localparam int POS_OP   = LEN_INSN - 1;
    localparam int POS_IMMF = POS_OP - LEN_OPECODE;
    localparam int POS_RD   = POS_IMMF - LEN_IMMF;
    localparam int POS_RS   = POS_RD - LEN_REGNO;
    localparam int POS_CC   = LEN_IMM - 1;

    localparam logic [LEN_OPECODE-1:0] OP_NOP = LEN_OPECODE'(7'b111_1110);
    localparam logic [LEN_OPECODE-1:0] OP_HLT = LEN_OPECODE'(7'b111_1111);

`ifdef DECODE_NOP_DROP_EN
    localparam bit NOP_FORWARD = 1'b0;
`else
    localparam bit NOP_FORWARD = 1'b1;
`endif

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t                   state_q,     state_d;
    logic                     out_valid_q, out_valid_d;
    logic                     illegal_q,   illegal_d;
    logic [LEN_OPECODE-1:0]   opecode_q,   opecode_d;
    logic [LEN_IMMF-1:0]      immf_q,      immf_d;
    logic [LEN_REG-1:0]       data_rd_q,   data_rd_d;
    logic [LEN_REG-1:0]       data_rs_q,   data_rs_d;
    logic [LEN_CC-1:0]        cc_q,        cc_d;
    logic [LEN_IMM_EX-1:0]    imm_ex_q,    imm_ex_d;
    logic [LEN_REGNO-1:0]     rd_no_q,     rd_no_d;

    logic [LEN_OPECODE-1:0]   f_op;
    logic [LEN_IMMF-1:0]      f_immf;
    logic [LEN_REGNO-1:0]     f_rd;
    logic [LEN_REGNO-1:0]     f_rs;
    logic [LEN_CC-1:0]        f_cc;
    logic [LEN_IMM-1:0]       f_imm;

    logic                     op_is_hlt;
    logic                     op_is_nop;
    logic                     op_is_legal;
    logic                     accept;
    logic                     load;

    assign f_op   = insn[POS_OP -: LEN_OPECODE];
    assign f_immf = insn[POS_IMMF -: LEN_IMMF];
    assign f_rd   = insn[POS_RD -: LEN_REGNO];
    assign f_rs   = insn[POS_RS -: LEN_REGNO];
    assign f_cc   = insn[POS_CC -: LEN_CC];
    assign f_imm  = insn[LEN_IMM-1:0];

    // Register file addresses come straight from the word, valid or not.
    assign rf_addr_rd = f_rd;
    assign rf_addr_rs = f_rs;

    // Only RUN accepts, and only when the output slot is free or draining now.
    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign op_is_hlt   = (f_op == OP_HLT);
    assign op_is_nop   = (f_op == OP_NOP);
    assign op_is_legal = (f_op[LEN_OPECODE-1 -: 3] == 3'b000) ||
                         (f_op[LEN_OPECODE-1 -: 3] == 3'b001) ||
                         op_is_nop || op_is_hlt;

    // Only legal non-hlt words reach execute. nop is forwarded unless the drop build is used.
    assign load = accept && op_is_legal && !op_is_hlt && (!op_is_nop || NOP_FORWARD);

    // Next-state: RUN/HALT sequencing, output handshake, bundle capture, sticky illegal.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        illegal_d   = illegal_q;
        opecode_d   = opecode_q;
        immf_d      = immf_q;
        data_rd_d   = data_rd_q;
        data_rs_d   = data_rs_q;
        cc_d        = cc_q;
        imm_ex_d    = imm_ex_q;
        rd_no_d     = rd_no_q;

        case (state_q)
            ST_RUN: begin
                if (accept && op_is_hlt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (accept && !op_is_legal) begin
            illegal_d = 1'b1;
        end

        if (load) begin
            out_valid_d = 1'b1;
            opecode_d   = f_op;
            immf_d      = f_immf;
            data_rd_d   = rf_data_rd;
            data_rs_d   = rf_data_rs;
            cc_d        = f_cc;
            imm_ex_d    = {{(LEN_IMM_EX-LEN_IMM){f_imm[LEN_IMM-1]}}, f_imm};
            rd_no_d     = f_rd;
        end
    end

    // State and bundle registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            opecode_q   <= '0;
            immf_q      <= '0;
            data_rd_q   <= '0;
            data_rs_q   <= '0;
            cc_q        <= '0;
            imm_ex_q    <= '0;
            rd_no_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            opecode_q   <= opecode_d;
            immf_q      <= immf_d;
            data_rd_q   <= data_rd_d;
            data_rs_q   <= data_rs_d;
            cc_q        <= cc_d;
            imm_ex_q    <= imm_ex_d;
            rd_no_q     <= rd_no_d;
        end
    end

    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign halted    = (state_q == ST_HALT);
    assign opecode   = opecode_q;
    assign immf      = immf_q;
    assign data_rd   = data_rd_q;
    assign data_rs   = data_rs_q;
    assign cc        = cc_q;
    assign imm_ex    = imm_ex_q;
    assign rd_no     = rd_no_q;

endmodule

// File: tb/tb_decode.sv
// Testbench for decode: directed scenarios followed by a randomized stream
// checked against a behavioural model of the decode rules.

module tb_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] insn = '0;
    logic [3:0]  rf_addr_rd, rf_addr_rs;
    logic [31:0] rf_data_rd = '0, rf_data_rs = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  opecode;
    logic [0:0]  immf;
    logic [31:0] data_rd, data_rs;
    logic [3:0]  cc;
    logic [31:0] imm_ex;
    logic [3:0]  rd_no;
    logic        halted;
    logic        resume = 1'b0;
    logic        illegal;

    logic [111:0] obs_bundle;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef DECODE_NOP_DROP_EN
    localparam bit NOP_DROP = 1'b1;
`else
    localparam bit NOP_DROP = 1'b0;
`endif

    decode dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .insn(insn),
        .rf_addr_rd(rf_addr_rd), .rf_addr_rs(rf_addr_rs),
        .rf_data_rd(rf_data_rd), .rf_data_rs(rf_data_rs),
        .out_valid(out_valid), .out_ready(out_ready),
        .opecode(opecode), .immf(immf), .data_rd(data_rd), .data_rs(data_rs),
        .cc(cc), .imm_ex(imm_ex), .rd_no(rd_no),
        .halted(halted), .resume(resume), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs_bundle = {opecode, immf, data_rd, data_rs, cc, imm_ex, rd_no};

    function automatic logic [31:0] mk_insn(input logic [6:0] op, input logic f,
                                             input logic [3:0] rd, input logic [3:0] rs,
                                             input logic [15:0] imm);
        return {op, f, rd, rs, imm};
    endfunction

    // Expected bundle from the field rules, using plain integer arithmetic.
    function automatic logic [111:0] exp_bundle(input logic [31:0] w,
                                                 input logic [31:0] drd, input logic [31:0] drs);
        int unsigned u;
        int unsigned imm;
        logic [31:0] ie;
        u   = w;
        imm = u % 65536;
        ie  = (imm >= 32768) ? (imm + 32'hFFFF_0000) : imm;
        return {7'(u / 33554432), 1'((u / 16777216) % 2), drd, drs,
                4'((u / 4096) % 16), ie, 4'((u / 1048576) % 16)};
    endfunction

    task automatic applyStimulus(input logic iv, input logic [31:0] w, input logic ordy,
                                 input logic [31:0] drd, input logic [31:0] drs);
        in_valid   = iv;
        insn       = w;
        out_ready  = ordy;
        rf_data_rd = drd;
        rf_data_rs = drs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({out_valid, halted, illegal} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b want 000", {out_valid, halted, illegal});
        end
        tests_run++;
        if (obs_bundle !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bundle: got %h want 0", obs_bundle);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        applyStimulus(1'b1, 32'h0012_0005, 1'b0, 32'd7, 32'd9);
        #1;
        tests_run++;
        if ({in_ready, rf_addr_rd, rf_addr_rs} !== {1'b1, 4'd1, 4'd2}) begin
            tests_failed++;
            $display("[TB] FAIL basic_addr: got %b/%0d/%0d want 1/1/2", in_ready, rf_addr_rd, rf_addr_rs);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_valid: got %b want 1", out_valid);
        end
        tests_run++;
        if ({opecode, rd_no, data_rd, data_rs, imm_ex} !== {7'd0, 4'd1, 32'd7, 32'd9, 32'd5}) begin
            tests_failed++;
            $display("[TB] FAIL basic_bundle: got op=%0d rd=%0d drd=%0d drs=%0d imm=%h want 0 1 7 9 5",
                     opecode, rd_no, data_rd, data_rs, imm_ex);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w2;
        w2 = mk_insn(7'b001_0011, 1'b1, 4'd3, 4'd4, 16'h1234);
        applyStimulus(1'b1, w2, 1'b0, 32'd11, 32'd22);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready);
            end
            step();
            tests_run++;
            if ({out_valid, obs_bundle} !== {1'b1, exp_bundle(32'h0012_0005, 32'd7, 32'd9)}) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold[%0d]: got %b/%h", i, out_valid, obs_bundle);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL release_in_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, opecode, immf, rd_no, cc, data_rd, data_rs, imm_ex} !==
            {1'b1, 7'h13, 1'b1, 4'd3, 4'd1, 32'd11, 32'd22, 32'h0000_1234}) begin
            tests_failed++;
            $display("[TB] FAIL release_bundle: got %b/%h", out_valid, obs_bundle);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL drain_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_sign_ext();
        applyStimulus(1'b1, mk_insn(7'h05, 1'b1, 4'd2, 4'd6, 16'h8000), 1'b1, 32'd1, 32'd2);
        step();
        applyStimulus(1'b1, mk_insn(7'h15, 1'b0, 4'd5, 4'd7, 16'h7FFF), 1'b1, 32'd3, 32'd4);
        tests_run++;
        if ({out_valid, imm_ex, cc} !== {1'b1, 32'hFFFF_8000, 4'h8}) begin
            tests_failed++;
            $display("[TB] FAIL sext_neg: got %b/%h/%h want 1/ffff8000/8", out_valid, imm_ex, cc);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, imm_ex, opecode, rd_no} !== {1'b1, 32'h0000_7FFF, 7'h15, 4'd5}) begin
            tests_failed++;
            $display("[TB] FAIL sext_pos: got %b/%h/%h/%0d want 1/00007fff/15/5", out_valid, imm_ex, opecode, rd_no);
        end
        step();
    endtask

    task automatic test_halt();
        logic [31:0] wl;
        applyStimulus(1'b1, mk_insn(7'h7F, 1'b0, 4'd0, 4'd0, 16'h0), 1'b1, 32'd0, 32'd0);
        step();
        wl = mk_insn(7'h0A, 1'b0, 4'd9, 4'd8, 16'hFFFE);
        applyStimulus(1'b1, wl, 1'b1, 32'hAA, 32'hBB);
        tests_run++;
        if ({halted, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL halt_enter: got %b want 10", {halted, out_valid});
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL halt_in_ready[%0d]: got %b want 0", i, in_ready);
            end
            step();
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        tests_run++;
        if ({halted, in_ready, out_valid} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL halt_resume: got %b want 010", {halted, in_ready, out_valid});
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, obs_bundle} !== {1'b1, 7'h0A, 1'b0, 32'hAA, 32'hBB, 4'hF, 32'hFFFF_FFFE, 4'd9}) begin
            tests_failed++;
            $display("[TB] FAIL halt_flow: got %b/%h", out_valid, obs_bundle);
        end
        step();
    endtask

    task automatic test_illegal();
        applyStimulus(1'b1, mk_insn(7'b010_0000, 1'b0, 4'd1, 4'd1, 16'h1), 1'b1, 32'd5, 32'd5);
        step();
        applyStimulus(1'b1, mk_insn(7'h1C, 1'b1, 4'd4, 4'd2, 16'h0042), 1'b1, 32'd44, 32'd55);
        tests_run++;
        if ({illegal, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL illegal_set: got %b want 10", {illegal, out_valid});
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({illegal, out_valid, opecode, data_rd} !== {1'b1, 1'b1, 7'h1C, 32'd44}) begin
            tests_failed++;
            $display("[TB] FAIL illegal_sticky: got %b/%b/%h/%0d want 1/1/1c/44", illegal, out_valid, opecode, data_rd);
        end
        step();
    endtask

    task automatic test_nop();
        logic       exp_v;
        logic [6:0] exp_op;
        exp_v  = !NOP_DROP;
        exp_op = NOP_DROP ? 7'h1C : 7'h7E;
        applyStimulus(1'b1, mk_insn(7'h7E, 1'b0, 4'd0, 4'd0, 16'h0), 1'b1, 32'd0, 32'd0);
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, opecode} !== {exp_v, exp_op}) begin
            tests_failed++;
            $display("[TB] FAIL nop: got %b/%h want %b/%h", out_valid, opecode, exp_v, exp_op);
        end
        step();
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, mk_insn(7'h03, 1'b1, 4'd7, 4'd7, 16'h9999), 1'b0, 32'd77, 32'd88);
        step();
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_pending: got %b want 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, halted, illegal, obs_bundle} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_async: got %b%b%b/%h want all 0", out_valid, halted, illegal, obs_bundle);
        end
        out_ready = 1'b1;
        step();
        step();
        tests_run++;
        if ({out_valid, obs_bundle} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_no_accept: got %b/%h want 0", out_valid, obs_bundle);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        tests_run++;
        if ({out_valid, illegal} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_after: got %b want 00", {out_valid, illegal});
        end
    endtask

    task automatic test_random();
        logic         m_valid = 1'b0;
        logic         m_halt  = 1'b0;
        logic         m_ill   = 1'b0;
        logic [111:0] m_bundle = '0;
        logic         exp_ready, acc;
        int unsigned  op, k;
        logic [6:0]   opv;
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 11);
            if (k < 7)       opv = 7'($urandom_range(0, 31));
            else if (k == 7) opv = 7'h7E;
            else if (k == 8) opv = 7'h7F;
            else if (k == 9) opv = {3'($urandom_range(2, 6)), 4'($urandom)};
            else             opv = 7'($urandom_range(112, 125));
            applyStimulus($urandom_range(0, 3) != 0,
                          mk_insn(opv, 1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom)),
                          $urandom_range(0, 2) != 0, $urandom, $urandom);
            resume = ($urandom_range(0, 3) == 0);
            #1;
            exp_ready = !m_halt && (!m_valid || out_ready);
            tests_run++;
            if ({in_ready, rf_addr_rd, rf_addr_rs} !== {exp_ready, 4'((insn / 1048576) % 16), 4'((insn / 65536) % 16)}) begin
                tests_failed++;
                $display("[TB] FAIL rand_ready[%0d]: got %b/%0d/%0d want %b", n, in_ready, rf_addr_rd, rf_addr_rs, exp_ready);
            end
            acc = in_valid && exp_ready;
            op  = insn / 33554432;
            m_valid = m_valid && !out_ready;
            if (m_halt && resume) m_halt = 1'b0;
            if (acc) begin
                if (op == 127) m_halt = 1'b1;
                else if (!(op < 32 || op == 126)) m_ill = 1'b1;
                else if (!(op == 126 && NOP_DROP)) begin
                    m_valid  = 1'b1;
                    m_bundle = exp_bundle(insn, rf_data_rd, rf_data_rs);
                end
            end
            step();
            tests_run++;
            if ({out_valid, halted, illegal} !== {m_valid, m_halt, m_ill}) begin
                tests_failed++;
                $display("[TB] FAIL rand_flags[%0d]: got %b want %b", n, {out_valid, halted, illegal}, {m_valid, m_halt, m_ill});
            end
            if (m_valid) begin
                tests_run++;
                if (obs_bundle !== m_bundle) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_bundle[%0d]: got %h want %h", n, obs_bundle, m_bundle);
                end
            end
        end
        in_valid = 1'b0;
        resume   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_sign_ext();
        test_halt();
        test_illegal();
        test_nop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
